// File: rtl/assoc_cache_tag_ctrl.sv
// -----------------------------------------------------------------------------
// assoc_cache_tag_ctrl
//
// Set-associative cache tag store with per-set age-counter LRU and the cache
// control FSM. The block sits between the CPU request strobes and the RAM
// handshake. It steers the data array through CHANNEL, SIG_RAM_LOAD and
// SIG_DATA_LOAD.
//
// Build option:
//   CACHE_WRITE_BACK_EN  defined   -> write-back. There is a dirty bit per
//                                     line, and a dirty victim is written
//                                     back (WRBACK) before it is refilled.
//                        undefined -> write-through, write-allocate. Each
//                                     write goes to RAM in WTHRU after the
//                                     data array is loaded.
//
// Ports:
//   CLK, RESET            clock; synchronous active-high reset
//   ADDR_INDEX, ADDR_TAG  request address, latched with the strobe
//   SIG_CPU_RD/WR         1-cycle request strobes (RD wins when both are high)
//   SIG_RAM_ACK           RAM transfer done (only a rising level counts)
//   CHANNEL               selected way: hit way or victim (registered)
//   HIT                   lookup result, held until the next lookup
//   ACK                   1-cycle CPU completion pulse
//   BUSY                  high outside IDLE
//   SIG_RAM_RD/WR         RAM line fetch / write request, held until ACK
//   SIG_RAM_LOAD          pulse: latch the RAM line into data way CHANNEL
//   SIG_DATA_LOAD         pulse: latch the CPU word into data way CHANNEL
//   WB_TAG                tag of the line being written to RAM
//
// COUNTER_SIZE must equal CHANNEL_SIZE. The ages in a set are always a
// permutation of 0..WAYS-1.
// -----------------------------------------------------------------------------
module assoc_cache_tag_ctrl #(
   parameter int ADDR_INDEX_SIZE = 6,
   parameter int ADDR_TAG_SIZE   = 6,
   parameter int CHANNEL_SIZE    = 3,
   parameter int COUNTER_SIZE    = 3
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic [ADDR_INDEX_SIZE-1:0] ADDR_INDEX,
   input  logic [ADDR_TAG_SIZE-1:0]   ADDR_TAG,
   input  logic                       SIG_CPU_RD,
   input  logic                       SIG_CPU_WR,
   input  logic                       SIG_RAM_ACK,
   output logic [CHANNEL_SIZE-1:0]    CHANNEL,
   output logic                       HIT,
   output logic                       ACK,
   output logic                       BUSY,
   output logic                       SIG_RAM_RD,
   output logic                       SIG_RAM_WR,
   output logic                       SIG_RAM_LOAD,
   output logic                       SIG_DATA_LOAD,
   output logic [ADDR_TAG_SIZE-1:0]   WB_TAG
);

   localparam int WAYS = 2**CHANNEL_SIZE;
   localparam int SETS = 2**ADDR_INDEX_SIZE;

   typedef enum logic [2:0] {
      ST_IDLE, ST_LOOKUP, ST_WRBACK, ST_FILL, ST_LOAD, ST_ACCESS, ST_WTHRU
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_TAG_SIZE-1:0]   tag_mem   [SETS][WAYS];
   logic [WAYS-1:0]            valid_mem [SETS];
   logic [COUNTER_SIZE-1:0]    age_mem   [SETS][WAYS];
`ifdef CACHE_WRITE_BACK_EN
   logic [WAYS-1:0]            dirty_mem [SETS];
   logic                       dirty_set;
`endif

   logic [ADDR_INDEX_SIZE-1:0] index_q;
   logic [ADDR_TAG_SIZE-1:0]   tag_q;
   logic                       op_wr_q;
   logic                       ram_ack_q;
   logic                       ram_ack_rise;

   logic [WAYS-1:0]            hit_vec;
   logic                       lookup_hit;
   logic [CHANNEL_SIZE-1:0]    hit_way;
   logic [CHANNEL_SIZE-1:0]    victim_way;
   logic                       victim_free;
   logic                       victim_dirty;

   logic [CHANNEL_SIZE-1:0]    channel_d;
   logic [ADDR_TAG_SIZE-1:0]   wb_tag_d;
   logic                       hit_d, ack_d, data_load_d;
   logic                       req_accept, install_en, touch_en;

   // A RAM ACK held high for several cycles completes only one transfer.
   assign ram_ack_rise = SIG_RAM_ACK && !ram_ack_q;

   // Tag compare and victim choice for the latched set.
   always_comb begin
      hit_vec     = '0;
      hit_way     = '0;
      victim_way  = '0;
      victim_free = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         hit_vec[w] = valid_mem[index_q][w] && (tag_mem[index_q][w] == tag_q);
         if (hit_vec[w]) hit_way = CHANNEL_SIZE'(w);
      end
      // The lowest-index invalid way is filled first. The scan runs downward
      // so that the last write is the lowest index.
      for (int w = WAYS-1; w >= 0; w--) begin
         if (!valid_mem[index_q][w]) begin
            victim_way  = CHANNEL_SIZE'(w);
            victim_free = 1'b1;
         end
      end
      if (!victim_free) begin
         for (int w = 0; w < WAYS; w++) begin
            if (age_mem[index_q][w] == COUNTER_SIZE'(WAYS-1)) victim_way = CHANNEL_SIZE'(w);
         end
      end
   end

   assign lookup_hit = |hit_vec;

`ifdef CACHE_WRITE_BACK_EN
   assign victim_dirty = valid_mem[index_q][victim_way] && dirty_mem[index_q][victim_way];
`else
   assign victim_dirty = 1'b0;
`endif

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge CLK) begin
      if (RESET) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      // NOTE: each signal gets a default value first, so no latches are inferred.
      state_d     = state_q;
      channel_d   = CHANNEL;
      hit_d       = HIT;
      wb_tag_d    = WB_TAG;
      ack_d       = 1'b0;
      data_load_d = 1'b0;
      req_accept  = 1'b0;
      install_en  = 1'b0;
      touch_en    = 1'b0;
`ifdef CACHE_WRITE_BACK_EN
      dirty_set   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (SIG_CPU_RD || SIG_CPU_WR) begin
               req_accept = 1'b1;
               state_d    = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            hit_d = lookup_hit;
            if (lookup_hit) begin
               channel_d = hit_way;
               state_d   = ST_ACCESS;
            end else begin
               channel_d = victim_way;
               if (victim_dirty) begin
                  wb_tag_d = tag_mem[index_q][victim_way];
                  state_d  = ST_WRBACK;
               end else begin
                  state_d  = ST_FILL;
               end
            end
         end
         ST_WRBACK: if (ram_ack_rise) state_d = ST_FILL;
         ST_FILL:   if (ram_ack_rise) state_d = ST_LOAD;
         ST_LOAD: begin
            install_en = 1'b1;
            state_d    = ST_ACCESS;
         end
         ST_ACCESS: begin
            touch_en = 1'b1;
            if (!op_wr_q) begin
               ack_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               data_load_d = 1'b1;
`ifdef CACHE_WRITE_BACK_EN
               dirty_set = 1'b1;
               ack_d     = 1'b1;
               state_d   = ST_IDLE;
`else
               wb_tag_d = tag_q;
               state_d  = ST_WTHRU;
`endif
            end
         end
         ST_WTHRU: begin
            if (ram_ack_rise) begin
               ack_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign BUSY         = (state_q != ST_IDLE);
   assign SIG_RAM_RD   = (state_q == ST_FILL);
   assign SIG_RAM_WR   = (state_q == ST_WRBACK) || (state_q == ST_WTHRU);
   assign SIG_RAM_LOAD = (state_q == ST_LOAD);

   // Per-line state and registered outputs. The valid, dirty and age arrays
   // are reset because lookup depends on them.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int s = 0; s < SETS; s++) begin
            valid_mem[s] <= '0;
`ifdef CACHE_WRITE_BACK_EN
            dirty_mem[s] <= '0;
`endif
            for (int w = 0; w < WAYS; w++) age_mem[s][w] <= COUNTER_SIZE'(w);
         end
         index_q       <= '0;
         tag_q         <= '0;
         op_wr_q       <= 1'b0;
         ram_ack_q     <= 1'b0;
         CHANNEL       <= '0;
         HIT           <= 1'b0;
         ACK           <= 1'b0;
         SIG_DATA_LOAD <= 1'b0;
         WB_TAG        <= '0;
      end else begin
         ram_ack_q     <= SIG_RAM_ACK;
         CHANNEL       <= channel_d;
         HIT           <= hit_d;
         ACK           <= ack_d;
         SIG_DATA_LOAD <= data_load_d;
         WB_TAG        <= wb_tag_d;
         if (req_accept) begin
            index_q <= ADDR_INDEX;
            tag_q   <= ADDR_TAG;
            op_wr_q <= !SIG_CPU_RD;
         end
         if (install_en) begin
            valid_mem[index_q][CHANNEL] <= 1'b1;
`ifdef CACHE_WRITE_BACK_EN
            dirty_mem[index_q][CHANNEL] <= 1'b0;
`endif
         end
`ifdef CACHE_WRITE_BACK_EN
         if (dirty_set) dirty_mem[index_q][CHANNEL] <= 1'b1;
`endif
         // LRU touch: ways younger than the touched way age by one, and the
         // touched way becomes the youngest.
         if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
               if (CHANNEL_SIZE'(w) == CHANNEL)
                  age_mem[index_q][w] <= '0;
               else if (age_mem[index_q][w] < age_mem[index_q][CHANNEL])
                  age_mem[index_q][w] <= age_mem[index_q][w] + 1'b1;
            end
         end
      end
   end

   // NOTE: the tag array has no reset. A stale tag is never used, because
   // every lookup is qualified by a valid bit, and the valid bits do reset.
   always_ff @(posedge CLK) begin
      if (install_en) tag_mem[index_q][CHANNEL] <= tag_q;
   end

endmodule

// File: tb/tb_assoc_cache_tag_ctrl.sv
`timescale 1ns/1ps
module tb_assoc_cache_tag_ctrl;

   localparam int IW   = 6;
   localparam int TW   = 6;
   localparam int CW   = 3;
   localparam int WAYS = 8;
   localparam int SETS = 64;
`ifdef CACHE_WRITE_BACK_EN
   localparam bit WB_MODE = 1'b1;
`else
   localparam bit WB_MODE = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RESET;
   logic [IW-1:0] ADDR_INDEX;
   logic [TW-1:0] ADDR_TAG;
   logic          SIG_CPU_RD, SIG_CPU_WR, SIG_RAM_ACK;
   logic [CW-1:0] CHANNEL;
   logic          HIT, ACK, BUSY, SIG_RAM_RD, SIG_RAM_WR, SIG_RAM_LOAD, SIG_DATA_LOAD;
   logic [TW-1:0] WB_TAG;

   always #5 CLK = ~CLK;

   assoc_cache_tag_ctrl dut (
      .CLK(CLK), .RESET(RESET), .ADDR_INDEX(ADDR_INDEX), .ADDR_TAG(ADDR_TAG),
      .SIG_CPU_RD(SIG_CPU_RD), .SIG_CPU_WR(SIG_CPU_WR), .SIG_RAM_ACK(SIG_RAM_ACK),
      .CHANNEL(CHANNEL), .HIT(HIT), .ACK(ACK), .BUSY(BUSY),
      .SIG_RAM_RD(SIG_RAM_RD), .SIG_RAM_WR(SIG_RAM_WR), .SIG_RAM_LOAD(SIG_RAM_LOAD),
      .SIG_DATA_LOAD(SIG_DATA_LOAD), .WB_TAG(WB_TAG)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model. Each set keeps an ordered list of its ways, most
   // recently used first. The victim is the last way in the list.
   bit m_valid [SETS][WAYS];
   bit m_dirty [SETS][WAYS];
   int m_tag   [SETS][WAYS];
   int m_lru   [SETS][WAYS];
   int exp_ram[$];           // expected RAM ops: 256+tag for a write, 0 for a read

   task automatic model_reset();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
            m_lru[s][w]   = w;
         end
   endtask

   task automatic model_touch(input int s, input int w);
      int p = 0;
      for (int i = 0; i < WAYS; i++) if (m_lru[s][i] == w) p = i;
      for (int i = p; i > 0; i--) m_lru[s][i] = m_lru[s][i-1];
      m_lru[s][0] = w;
   endtask

   task automatic model_op(input int s, input int t, input bit wr, output bit hit, output int ch);
      exp_ram.delete();
      hit = 1'b0;
      ch  = 0;
      for (int w = 0; w < WAYS; w++)
         if (m_valid[s][w] && m_tag[s][w] == t) begin hit = 1'b1; ch = w; end
      if (!hit) begin
         int v = -1;
         for (int w = WAYS-1; w >= 0; w--) if (!m_valid[s][w]) v = w;
         if (v < 0) v = m_lru[s][WAYS-1];
         ch = v;
         if (WB_MODE && m_valid[s][v] && m_dirty[s][v]) exp_ram.push_back(256 + m_tag[s][v]);
         exp_ram.push_back(0);
         m_valid[s][v] = 1'b1;
         m_tag[s][v]   = t;
         m_dirty[s][v] = 1'b0;
      end
      model_touch(s, ch);
      if (wr) begin
         if (WB_MODE) m_dirty[s][ch] = 1'b1;
         else         exp_ram.push_back(256 + t);
      end
   endtask

   task automatic check_idle(input string pfx);
      check({pfx, "_channel"}, CHANNEL, 0);
      check({pfx, "_hit"}, HIT, 0);
      check({pfx, "_ack"}, ACK, 0);
      check({pfx, "_busy"}, BUSY, 0);
      check({pfx, "_ram_rd"}, SIG_RAM_RD, 0);
      check({pfx, "_ram_wr"}, SIG_RAM_WR, 0);
      check({pfx, "_ram_load"}, SIG_RAM_LOAD, 0);
      check({pfx, "_data_load"}, SIG_DATA_LOAD, 0);
      check({pfx, "_wb_tag"}, WB_TAG, 0);
   endtask

   // Runs one CPU request to completion and serves the RAM with random
   // delays and ACK lengths. The DUT is sampled on the falling edge.
   task automatic do_op(input bit wr, input bit both, input bit noise, input int s, input int t);
      bit e_hit, wr_eff, pend, got_hit, dl_at_ack, fill_next;
      int e_ch, got_ch, acks, rl, dl, edges, ack_edge, fill_edge, last_edge, dly, hold;
      int got_ram[$];
      acks = 0; rl = 0; dl = 0; edges = 0; ack_edge = 0; fill_edge = 0; last_edge = 0;
      dly = 0; hold = 0; pend = 0; got_hit = 0; got_ch = 0; dl_at_ack = 0; fill_next = 0;
      wr_eff = wr && !both;
      model_op(s, t, wr_eff, e_hit, e_ch);
      ADDR_INDEX = IW'(s);
      ADDR_TAG   = TW'(t);
      SIG_CPU_RD = !wr_eff;
      SIG_CPU_WR = wr || both;
      while (edges < 200) begin
         @(posedge CLK);
         edges++;
         @(negedge CLK);
         if (edges == 1) begin
            SIG_CPU_RD = noise;
            SIG_CPU_WR = 1'b0;
            ADDR_INDEX = IW'($urandom);
            ADDR_TAG   = TW'($urandom);
            check("busy_after_strobe", BUSY, 1);
         end else if (edges == 2) begin
            SIG_CPU_RD = 1'b0;
         end
         if (SIG_RAM_LOAD) rl++;
         if (SIG_DATA_LOAD) dl++;
         if (ACK) begin
            acks++;
            if (acks == 1) begin
               ack_edge  = edges;
               got_hit   = HIT;
               got_ch    = int'(CHANNEL);
               dl_at_ack = SIG_DATA_LOAD;
               check("idle_at_ack", BUSY, 0);
            end
         end
         if (hold > 0) begin
            hold--;
            if (hold == 0) SIG_RAM_ACK = 1'b0;
         end else if (pend) begin
            if (dly == 0) begin
               SIG_RAM_ACK = 1'b1;
               hold = $urandom_range(2, 1);
               pend = 1'b0;
               last_edge = edges + 1;
               if (fill_next) fill_edge = edges + 1;
            end else begin
               dly--;
            end
         end else if (SIG_RAM_RD || SIG_RAM_WR) begin
            got_ram.push_back(SIG_RAM_WR ? 256 + int'(WB_TAG) : 0);
            fill_next = SIG_RAM_RD;
            pend = 1'b1;
            dly  = $urandom_range(3, 0);
         end
         if (acks > 0 && edges >= ack_edge + 3 && hold == 0 && !pend) break;
      end
      check("ack_count", acks, 1);
      if (acks > 0) begin
         check("hit", got_hit, e_hit);
         check("channel", got_ch, e_ch);
         check("ram_load_pulses", rl, e_hit ? 0 : 1);
         check("data_load_pulses", dl, wr_eff ? 1 : 0);
         check("ram_op_count", got_ram.size(), exp_ram.size());
         for (int i = 0; i < got_ram.size() && i < exp_ram.size(); i++)
            check("ram_op", got_ram[i], exp_ram[i]);
         if (wr_eff && !WB_MODE) check("wthru_latency", ack_edge, last_edge);
         else if (e_hit)         check("hit_latency", ack_edge, 3);
         else                    check("miss_latency", ack_edge, fill_edge + 2);
         if (wr_eff && WB_MODE)  check("dload_with_ack", dl_at_ack, 1);
      end
   endtask

   task automatic reset_during_fill(input int s, input int t);
      int n = 0;
      ADDR_INDEX = IW'(s);
      ADDR_TAG   = TW'(t);
      SIG_CPU_RD = 1'b1;
      @(negedge CLK);
      SIG_CPU_RD = 1'b0;
      while (!SIG_RAM_RD && n < 20) begin
         @(negedge CLK);
         n++;
      end
      check("fill_reached", SIG_RAM_RD, 1);
      RESET = 1'b1;
      @(negedge CLK);
      check_idle("rst_fill");
      RESET = 1'b0;
      model_reset();
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b1; SIG_CPU_RD = 1'b0; SIG_CPU_WR = 1'b0; SIG_RAM_ACK = 1'b0;
      ADDR_INDEX = '0; ADDR_TAG = '0;
      model_reset();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check_idle("reset");
      RESET = 1'b0;
      @(negedge CLK);

      // First access misses into way 0. Repeating it hits.
      do_op(0, 0, 0, 0, 1);
      do_op(0, 0, 0, 0, 1);
      // Fill set 0 with tags 2..8, reread tag 1, then evict the oldest with tag 9.
      for (int t = 2; t <= 8; t++) do_op(0, 0, 0, 0, t);
      do_op(0, 0, 0, 0, 1);
      do_op(0, 0, 0, 0, 9);
      do_op(0, 0, 0, 0, 1);
      // Write hit.
      do_op(1, 0, 0, 0, 1);
      // Dirty tag 2 becomes the LRU line of set 1 and is evicted by tag 10.
      for (int t = 1; t <= 8; t++) do_op(0, 0, 0, 1, t);
      do_op(1, 0, 0, 1, 2);
      do_op(0, 0, 0, 1, 1);
      for (int t = 3; t <= 8; t++) do_op(0, 0, 0, 1, t);
      do_op(0, 0, 0, 1, 10);
      // RD and WR in the same cycle, then a strobe while BUSY.
      do_op(1, 1, 0, 0, 9);
      do_op(0, 0, 1, 0, 5);
      do_op(1, 0, 1, 1, 11);

      // Random traffic over a few sets, with enough tags to force evictions.
      for (int i = 0; i < 300; i++)
         do_op($urandom_range(2, 0) == 0, $urandom_range(9, 0) == 0, $urandom_range(7, 0) == 0,
               $urandom_range(3, 0), $urandom_range(11, 0));

      // A reset during FILL aborts the request, and earlier hits now miss.
      do_op(0, 0, 0, 0, 1);
      reset_during_fill(20, 7);
      do_op(0, 0, 0, 0, 1);
      check("post_reset_hit", HIT, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
